// File: rtl/parity_frame_rx_pkg.sv
// parity_frame_rx_pkg: shared FSM state encoding and parity-sense constants
package parity_frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 0;

endpackage

// File: rtl/parity_frame_rx_word_parity.sv
// word_parity: N-bit XOR reduction of a word
module word_parity #(
    parameter int N = 4
) (
    input  logic [N-1:0] word,
    output logic         par
);

    assign par = ^word;

endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: framed serial receiver with parity/framing checks and saturating error count
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int N     = 4,
    parameter int EVEN  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             bit_en,
    output logic [N-1:0]     data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam int IW = $clog2(N + 1);

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic [N-1:0]  sh;
    logic          p;
    logic          x;
    logic          par_bad;
    logic          err_now;

    word_parity #(.N(N)) u_par (
        .word(sh),
        .par (x)
    );

    assign par_bad = x ^ p ^ (EVEN == PAR_EVEN ? 1'b0 : 1'b1);
    assign err_now = bit_en && state == STOP && (sin ? par_bad : 1'b1);
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bit_en) begin
            case (state)
                IDLE:      state_n = sin ? IDLE : DATA;
                DATA:      state_n = idx == IW'(N - 1) ? PARITY : DATA;
                PARITY:    state_n = STOP;
                STOP:      state_n = sin ? IDLE : WAIT_IDLE;
                WAIT_IDLE: state_n = sin ? IDLE : WAIT_IDLE;
                default:   state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            sh         <= '0;
            p          <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: idx <= '0;
                    DATA: begin
                        for (int i = 0; i < N; i++)
                            if (idx == IW'(i)) sh[i] <= sin;
                        idx <= idx + 1'b1;
                    end
                    PARITY: p <= sin;
                    STOP: begin
                        valid      <= sin;
                        parity_err <= sin & par_bad;
                        frame_err  <= ~sin;
                        if (sin) data_out <= sh;
                    end
                    default: ;
                endcase
            end
            // saturate rather than wrap so a flood of errors stays visible
            if (err_now && !(&err_count)) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial frame receiver that sits upstream of the N-bit parity detector stage.
- Deserialises a framed serial stream into an N-bit word: start bit (0), N data bits LSB first, one parity bit, stop bit (1).
- Checks the received parity against the data and presents the word with a one-cycle valid strobe.
- Reports parity and framing errors and keeps a saturating error count.

Parameters:
- N, 4, number of data bits per frame.
- EVEN, 1, parity sense. 1 = even parity (XOR of data and parity bit must be 0). 0 = odd parity (XOR must be 1).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data in; idles high.
- bit_en  input  1  one-cycle strobe per bit period; sin is sampled only when bit_en=1.
- data_out  output  N  last correctly framed word; held until the next valid.
- valid  output  1  one-cycle pulse: new word on data_out.
- parity_err  output  1  one-cycle pulse coincident with valid when the parity check fails.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- err_count  output  CNT_W  count of parity plus framing errors, saturating.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, bit index 0, shift register 0. Reset asserted mid-frame aborts the frame with no strobes.
- Sampling: when bit_en=0 nothing advances and sin is ignored. Glitches on sin between strobes have no effect.
- IDLE: on bit_en with sin=0 (start bit), clear bit index and go to DATA. On bit_en with sin=1, stay in IDLE.
- DATA: on each bit_en, shift sin into bit position idx (LSB first) and increment idx. After the N-th bit go to PARITY.
- PARITY: on bit_en, capture sin as p and go to STOP.
- STOP, on bit_en with sin=1:
  - Register valid=1 and load data_out with the word.
  - parity_err = (XOR-reduce(data) ^ p) ^ (EVEN ? 0 : 1).
  - Go to IDLE.
- STOP, on bit_en with sin=0:
  - frame_err=1, valid=0, parity_err=0; data_out unchanged.
  - Go to WAIT_IDLE.
- WAIT_IDLE: on bit_en with sin=1 go to IDLE. A low line is not taken as a new start bit until a high sample has been seen. busy stays 1.
- Latency: valid, parity_err and frame_err are registered. They assert on the clk edge that samples the stop bit and last exactly one cycle.
- err_count: increments by 1 on a parity_err or frame_err pulse (never both in one cycle). Saturates at all-ones and never wraps.
- A frame with a parity error still asserts valid and updates data_out. The consumer decides whether to discard it.
- Back-to-back frames: a start bit on the first bit_en after the stop bit is accepted.
- bit_en on consecutive clocks is legal; the minimum bit period is one cycle.

Decomposition:
- Shared package: state encoding (IDLE, DATA, PARITY, STOP, WAIT_IDLE) and the parity-sense constants PAR_EVEN=1, PAR_ODD=0.
- One sub-module, word_parity: a parameterised N-bit XOR reduction producing 1 bit. Instantiated once on the assembled word.
- Bit index width: clog2(N+1).

Test Plan:
- N=4, EVEN=1, bit_en every 4 cycles; frame 0,1,1,0,1,p=1,1 (data 4'hB) -> valid 1 cycle, data_out=4'hB, parity_err=0, err_count=0.
- Same frame with p=0 -> valid=1, parity_err=1, data_out=4'hB, err_count=1.
- Frame 4'h3, p=0, stop bit=0 -> frame_err=1, valid=0, data_out keeps its previous value, busy=1 until a sin=1 sample, then IDLE.
- rst pulsed after 2 data bits -> all outputs 0 immediately. A following frame 4'h5, p=0, stop 1 -> data_out=4'h5, parity_err=0.
- CNT_W=2: five consecutive parity-bad frames -> err_count goes 1,2,3,3,3.
- Irregular bit_en gaps (1-7 cycles) and sin toggling between strobes, frame 4'hA, p=0 -> data_out=4'hA, no error; EVEN=0 build with the same frame -> parity_err=1.
